// File: rtl/alu_selftest_pkg.sv
// Shared definitions for the ALU self-test sequencer: function codes, vector
// format, FSM states and the built-in vector table.
package alu_selftest_pkg;

    localparam int VEC_DW      = 32;
    localparam int VEC_FW      = 3;
    localparam int DEF_NUM_VEC = 6;

    localparam logic [VEC_FW-1:0] ADD = 3'b001;
    localparam logic [VEC_FW-1:0] SUB = 3'b010;
    localparam logic [VEC_FW-1:0] AND = 3'b011;
    localparam logic [VEC_FW-1:0] OR  = 3'b100;
    localparam logic [VEC_FW-1:0] SLT = 3'b101;

    typedef struct packed {
        logic [VEC_DW-1:0] a;
        logic [VEC_DW-1:0] b;
        logic [VEC_FW-1:0] func;
        logic [VEC_DW-1:0] expected;
    } alu_vec_t;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    // Entries past the end of the table read as all-zero vectors.
    function automatic alu_vec_t def_vec(input int unsigned i);
        case (i)
            0:       def_vec = '{32'd25,        32'd24, ADD, 32'd49};
            1:       def_vec = '{32'd25,        32'd24, SUB, 32'd1};
            2:       def_vec = '{32'd25,        32'd24, AND, 32'd24};
            3:       def_vec = '{32'd25,        32'd24, OR,  32'd25};
            4:       def_vec = '{32'd25,        32'd24, SLT, 32'd0};
            5:       def_vec = '{32'hFFFF_FFE7, 32'd24, SLT, 32'd1};
            default: def_vec = '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// Combinational lookup of one self-test vector, resized to the ALU widths.
module alu_vec_rom
    import alu_selftest_pkg::*;
#(
    parameter int NUM_VEC = 6,
    parameter int DW      = 32,
    parameter int FW      = 3,
    parameter int IW      = 3
) (
    input  logic [IW-1:0] idx,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [FW-1:0] func,
    output logic [DW-1:0] expected
);

    alu_vec_t v;

    always_comb begin
        v = '0;
        if (int'(idx) < NUM_VEC)
            v = def_vec(32'(idx));
    end

    assign a        = DW'(v.a);
    assign b        = DW'(v.b);
    assign func     = FW'(v.func);
    assign expected = DW'(v.expected);

endmodule

// File: rtl/alu_selftest.sv
// Sequences the vector table through an external ALU, two cycles per vector,
// and reports error count, first failing index and pass.
// Build option: define ALU_SELFTEST_STOP_ON_FAIL_EN to end a run at its first mismatch.
module alu_selftest
    import alu_selftest_pkg::*;
#(
    parameter int NUM_VEC = 6,
    parameter int DW      = 32,
    parameter int FW      = 3,
    localparam int IW     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] alu_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [FW-1:0] alu_func,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_cnt,
    output logic [IW-1:0] first_fail_idx
);

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] rom_idx;
    logic [DW-1:0] rom_a, rom_b, rom_exp, exp_q;
    logic [FW-1:0] rom_func;
    logic          mismatch, last, stop_now;

    // The ROM always looks at the vector about to be loaded, so the expected
    // value of the vector under test is captured alongside the operands.
    assign rom_idx  = (state == S_SAMPLE) ? idx + IW'(1) : '0;
    assign mismatch = (alu_result != exp_q);
    assign last     = (idx == IW'(NUM_VEC - 1));

`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    alu_vec_rom #(.NUM_VEC(NUM_VEC), .DW(DW), .FW(FW), .IW(IW)) u_rom (
        .idx      (rom_idx),
        .a        (rom_a),
        .b        (rom_b),
        .func     (rom_func),
        .expected (rom_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_func       <= '0;
            exp_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_DRIVE;
                        idx            <= '0;
                        err_cnt        <= '0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        alu_a          <= rom_a;
                        alu_b          <= rom_b;
                        alu_func       <= rom_func;
                        exp_q          <= rom_exp;
                    end
                end
                S_DRIVE: state <= S_SAMPLE;
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                        if (err_cnt == 8'd0)
                            first_fail_idx <= idx;
                    end
                    if (last || stop_now) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 8'd0) && !mismatch;
                    end else begin
                        state    <= S_DRIVE;
                        idx      <= idx + IW'(1);
                        alu_a    <= rom_a;
                        alu_b    <= rom_b;
                        alu_func <= rom_func;
                        exp_q    <= rom_exp;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_selftest.sv
// Scoreboard bench for alu_selftest: stimulus queues the expected run summary,
// a monitor checks it when done rises.
module tb_alu_selftest;

    localparam int NV = 6;
    localparam int DW = 32;
    localparam int FW = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] alu_result, alu_a, alu_b;
    logic [FW-1:0] alu_func;
    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic [IW-1:0] first_fail_idx;

    int mode = 0;   // 0 correct ALU, 1 OR returns 0, 2 always all-ones
    int cyc = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int          t0;
        int          lat;
        logic [7:0]  err;
        logic [2:0]  ffi;
        logic        pass;
        logic [2:0]  func;
        logic [31:0] a;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_result = '0;
        case (alu_func)
            3'b001: alu_result = alu_a + alu_b;
            3'b010: alu_result = alu_a - alu_b;
            3'b011: alu_result = alu_a & alu_b;
            3'b100: alu_result = (mode == 1) ? 32'd0 : (alu_a | alu_b);
            3'b101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        if (mode == 2) alu_result = 32'hFFFF_FFFF;
    end

    alu_selftest #(.NUM_VEC(NV), .DW(DW), .FW(FW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .alu_result     (alu_result),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_func       (alu_func),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_idx (first_fail_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: one scoreboard entry per rising edge of done.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1, expected no run pending");
            end else begin
                mon_e = sb.pop_front();
                check("latency", cyc - mon_e.t0, mon_e.lat);
                check("err_cnt", err_cnt, mon_e.err);
                check("first_fail_idx", first_fail_idx, mon_e.ffi);
                check("pass", pass, mon_e.pass);
                check("busy_at_done", busy, 0);
                check("held_func", alu_func, mon_e.func);
                check("held_a", alu_a, mon_e.a);
            end
        end
        done_q <= done;
    end

    task automatic push_exp(input int lat, input logic [7:0] err, input logic [2:0] ffi,
                            input logic p, input logic [2:0] f, input logic [31:0] a);
        exp_t e;
        e.t0 = cyc; e.lat = lat; e.err = err; e.ffi = ffi;
        e.pass = p; e.func = f; e.a = a;
        sb.push_back(e);
    endtask

    // Pulse start for one edge and log the expected summary of the run.
    task automatic launch(input int lat, input logic [7:0] err, input logic [2:0] ffi,
                          input logic p, input logic [2:0] f, input logic [31:0] a);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        push_exp(lat, err, ffi, p, f, a);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d runs pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_func"}, alu_func, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_ffi"}, first_fail_idx, 0);
    endtask

    initial begin
        // Reset with start asserted: nothing may happen.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Correct ALU.
        mode = 0;
        launch(12, 8'd0, 3'd0, 1'b1, 3'b101, 32'hFFFF_FFE7);
        wait_drain(40);

        // OR vector corrupted.
        mode = 1;
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
        launch(8, 8'd1, 3'd3, 1'b0, 3'b100, 32'd25);
`else
        launch(12, 8'd1, 3'd3, 1'b0, 3'b101, 32'hFFFF_FFE7);
`endif
        wait_drain(40);

        // Every vector wrong.
        mode = 2;
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
        launch(2, 8'd1, 3'd0, 1'b0, 3'b001, 32'd25);
`else
        launch(12, 8'd6, 3'd0, 1'b0, 3'b101, 32'hFFFF_FFE7);
`endif
        wait_drain(40);

        // start held high: one run, then restart straight out of DONE.
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        push_exp(12, 8'd0, 3'd0, 1'b1, 3'b101, 32'hFFFF_FFE7);
        begin
            int n = 0;
            while (!done && n < 40) begin
                @(negedge clk); n++;
            end
        end
        check("hold_done_seen", done, 1);
        @(posedge clk); #1;
        push_exp(12, 8'd0, 3'd0, 1'b1, 3'b101, 32'hFFFF_FFE7);
        start = 1'b0;
        @(negedge clk);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        check("restart_err_cnt", err_cnt, 0);
        check("restart_pass", pass, 0);
        wait_drain(40);

        // Reset during vector 2, then a full clean run.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_func_v2", alu_func, 3'b011);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", busy, 0);
        launch(12, 8'd0, 3'd0, 1'b1, 3'b101, 32'hFFFF_FFE7);
        wait_drain(40);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_selftest.md
ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 SHALL have parameter NUM_VEC, default 6, number of test vectors in the table.
REQ-002 SHALL have parameter DW, default 32, ALU operand/result width.
REQ-003 SHALL have parameter FW, default 3, ALU function-code width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level sampled in IDLE/DONE; high begins a run.
REQ-008 alu_result  input  DW  ALU data output (combinational from alu_a/alu_b/alu_func).
REQ-009 alu_a  output  DW  registered operand a to ALU.
REQ-010 alu_b  output  DW  registered operand b to ALU.
REQ-011 alu_func  output  FW  registered function code to ALU.
REQ-012 busy  output  1  high in DRIVE/SAMPLE.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  valid when done; 1 = zero mismatches.
REQ-015 err_cnt  output  8  mismatch count, saturating at 255.
REQ-016 first_fail_idx  output  clog2(NUM_VEC)  index of first mismatching vector; 0 if none.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-018 IDLE or DONE with start=1 at an edge: idx<=0, err_cnt<=0, first_fail_idx<=0, pass<=0, go DRIVE.
REQ-019 DRIVE: alu_a/alu_b/alu_func <= table[idx] on the edge entering DRIVE; next state SAMPLE.
REQ-020 SAMPLE: at its closing edge compare alu_result to table[idx].expected (full DW bits, no sign handling).
REQ-021 Mismatch: err_cnt increments (holds at 255); first_fail_idx <= idx only on first mismatch of the run.
REQ-022 SAMPLE with idx==NUM_VEC-1: go DONE, pass <= (no mismatch in run including this one); else idx++, go DRIVE.
REQ-023 Each vector SHALL take exactly 2 cycles; done rises 2*NUM_VEC cycles after the edge that accepted start.
REQ-024 start SHALL be ignored in DRIVE/SAMPLE.
REQ-025 DONE holds all results and operand outputs until a new start.
REQ-026 alu_a/alu_b/alu_func SHALL change only on entry to DRIVE (stable through SAMPLE).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, idx=0 and all outputs to 0, including mid-run.
REQ-028 After rst_n release, no run begins until start is sampled high.

Configuration
REQ-029 Macro ALU_SELFTEST_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE goes directly to DONE with pass=0, err_cnt=1.
REQ-030 Macro undefined: all NUM_VEC vectors run regardless of mismatches.

Structure
REQ-031 Package alu_selftest_pkg SHALL hold: ALU func-code constants (ADD=3'b001, SUB=3'b010, AND=3'b011, OR=3'b100, SLT=3'b101), vector struct typedef {a,b,func,expected}, FSM state enum, default vector table.
REQ-032 Default table: {25,24,ADD,49},{25,24,SUB,1},{25,24,AND,24},{25,24,OR,25},{25,24,SLT,0},{-25,24,SLT,1}.
REQ-033 Sub-module alu_vec_rom SHALL provide combinational table lookup by idx.

Verification
REQ-034 Reset: rst_n=0 -> all outputs 0, busy=0, done=0; start ignored until release.
REQ-035 Correct ALU model, 1-cycle start pulse -> busy 12 cycles, done=1, pass=1, err_cnt=0, first_fail_idx=0.
REQ-036 Model corrupts vector 3 (OR returns 0) -> err_cnt=1, first_fail_idx=3, pass=0; done after 12 cycles, or 8 with ALU_SELFTEST_STOP_ON_FAIL_EN.
REQ-037 Model returns 0xFFFFFFFF always, macro undefined -> err_cnt=6, first_fail_idx=0, pass=0.
REQ-038 start held high throughout -> one run of 12 cycles, then immediate restart from DONE with counters cleared.
REQ-039 rst_n pulsed low during vector 2 -> outputs 0 asynchronously; subsequent start completes full pass run.
